pixel_window_streamer: RTL and testbench

//  Image-side feeder for the classifier datapath: accepts one IMG_DIM x IMG_DIM image as rows over a valid/ready port.

---
 rtl/pixel_window_streamer_if.sv | 33 +++
 rtl/pixel_window_streamer.sv | 131 +++++++++++++
 tb/tb_pixel_window_streamer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_window_streamer_if.sv
// Handshake bundle for pixel_window_streamer: row input stream and window output stream.
// Valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1;
// a source holds valid and its data stable until that edge, and ready may depend on state only.
interface pixel_window_streamer_if #(
  parameter int PIX_W   = 8,
  parameter int IMG_DIM = 3,
  parameter int WIN_DIM = 2
);
  localparam int NW1   = IMG_DIM - WIN_DIM + 1;
  localparam int NWIN  = NW1 * NW1;
  localparam int IDX_W = $clog2(NWIN);

  logic                             row_valid;
  logic                             row_ready;
  logic [IMG_DIM*PIX_W-1:0]         row_data;
  logic                             pix_valid;
  logic                             pix_ready;
  logic [WIN_DIM*WIN_DIM*PIX_W-1:0] pixels;
  logic [IDX_W-1:0]                 win_idx;
  logic                             win_last;

  // streamer side
  modport master (
    input  row_valid, row_data, pix_ready,
    output row_ready, pix_valid, pixels, win_idx, win_last
  );

  // image source / window consumer side
  modport slave (
    output row_valid, row_data, pix_ready,
    input  row_ready, pix_valid, pixels, win_idx, win_last
  );
endinterface

// File: rtl/pixel_window_streamer.sv
// pixel_window_streamer: loads one IMG_DIM x IMG_DIM image row by row (top row first) and
// streams every WIN_DIM x WIN_DIM stride-1 window, one packed word per handshake.
// Optional feature macro WIN_DBL_BUF_EN: ping/pong image buffers so the next image loads
// while the current one streams, with no bubble between images.
module pixel_window_streamer #(
  parameter int PIX_W   = 8,
  parameter int IMG_DIM = 3,
  parameter int WIN_DIM = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  pixel_window_streamer_if.master bus,
  output logic                   state_dbg
);
  localparam int NW1   = IMG_DIM - WIN_DIM + 1;
  localparam int NWIN  = NW1 * NW1;
  localparam int IDX_W = $clog2(NWIN);
  localparam int ROW_W = $clog2(IMG_DIM);
  localparam int NPIX  = WIN_DIM * WIN_DIM;
  localparam int RW    = IMG_DIM * PIX_W;
`ifdef WIN_DBL_BUF_EN
  localparam int NBUF  = 2;
`else
  localparam int NBUF  = 1;
`endif

  typedef enum logic {S_LOAD = 1'b0, S_STREAM = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [ROW_W-1:0]    row_cnt;
  logic [IDX_W-1:0]    win_cnt;
  logic [ROW_W-1:0]    row_addr;
  logic                row_fire, pix_fire, row_last, win_end;
  logic                next_img_ready;
  logic                wr_sel, rd_sel;
  logic [RW-1:0]       img_mem [NBUF][IMG_DIM];
  logic [NPIX*PIX_W-1:0] win_word;

  assign row_fire = bus.row_valid & bus.row_ready;
  assign pix_fire = bus.pix_valid & bus.pix_ready;
  assign row_last = (row_cnt == ROW_W'(IMG_DIM - 1));
  assign win_end  = (win_cnt == IDX_W'(NWIN - 1));
  // rows arrive top (r = IMG_DIM-1) first, so the row counter maps downwards
  assign row_addr = ROW_W'(IMG_DIM - 1) - row_cnt;

`ifdef WIN_DBL_BUF_EN
  logic [1:0] full, full_set, full_clr;
  assign full_set = (row_fire && row_last) ? (2'b01 << wr_sel) : 2'b00;
  assign full_clr = (pix_fire && win_end)  ? (2'b01 << rd_sel) : 2'b00;
  // while streaming, a completed load always lands in the idle buffer
  assign next_img_ready = full[~rd_sel] | (row_fire & row_last);

  // ping/pong bookkeeping: fill pointer, stream pointer, per-buffer full flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      full <= (full | full_set) & ~full_clr;
      if (row_fire && row_last) wr_sel <= ~wr_sel;
      if (pix_fire && win_end)  rd_sel <= ~rd_sel;
    end
  end
`else
  assign wr_sel         = 1'b0;
  assign rd_sel         = 1'b0;
  assign next_img_ready = 1'b0;
`endif

  // image storage; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (row_fire) img_mem[wr_sel][row_addr] <= bus.row_data;
  end

  // row and window counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_cnt <= '0;
      win_cnt <= '0;
    end else begin
      if (row_fire) row_cnt <= row_last ? '0 : row_cnt + 1'b1;
      if (pix_fire) win_cnt <= win_end ? '0 : win_cnt + 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LOAD;
    else      state <= state_nxt;
  end

  // next state: load until the bottom row lands, stream until the last window leaves
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:   if (row_fire && row_last) state_nxt = S_STREAM;
      S_STREAM: if (pix_fire && win_end && !next_img_ready) state_nxt = S_LOAD;
      default:  state_nxt = S_LOAD;
    endcase
  end

  // window assembly: row-major, MSB first, starting at the top-right of the window
  always_comb begin
    win_word = '0;
    for (int k = 0; k < NWIN; k++) begin
      if (win_cnt == IDX_W'(k)) begin
        for (int i = 0; i < WIN_DIM; i++) begin
          for (int j = 0; j < WIN_DIM; j++) begin
            win_word[(NPIX-1-(i*WIN_DIM+j))*PIX_W +: PIX_W] =
              img_mem[rd_sel][ROW_W'(IMG_DIM-1-(k/NW1)-i)][(IMG_DIM-1-(k%NW1)-j)*PIX_W +: PIX_W];
          end
        end
      end
    end
  end

  // outputs
  always_comb begin
    bus.pix_valid = (state == S_STREAM);
`ifdef WIN_DBL_BUF_EN
    bus.row_ready = ~full[wr_sel];
`else
    bus.row_ready = (state == S_LOAD);
`endif
    bus.win_idx   = win_cnt;
    bus.win_last  = (state == S_STREAM) && win_end;
    bus.pixels    = (state == S_STREAM) ? win_word : '0;
    state_dbg     = state;
  end
endmodule

// File: tb/tb_pixel_window_streamer.sv
// Directed and randomized bench for pixel_window_streamer with a window-list reference model.
module tb_pixel_window_streamer;
  localparam int NWIN = 4;

  logic clk;
  logic rst;
  logic state_dbg;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [34:0] exp_q[$];
  int   fire_cyc[$];
  logic [34:0] mon_e;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_pix;
  logic [1:0]  hold_idx;
  logic        hold_last;
  logic        rows_done;
  int          rnd_n;
  logic [23:0] ra, rb, rc;

  pixel_window_streamer_if #(.PIX_W(8), .IMG_DIM(3), .WIN_DIM(2)) bus ();

  pixel_window_streamer #(.PIX_W(8), .IMG_DIM(3), .WIN_DIM(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present one row after an idle gap, hold it until accepted
  task automatic send_row(input logic [23:0] d, input int gap);
    int   n;
    logic ok;
    repeat (gap) tick();
    bus.row_valid = 1'b1;
    bus.row_data  = d;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.row_ready;
      tick();
      n++;
    end
    bus.row_valid = 1'b0;
    check("row_accept", 64'(ok), 64'd1);
  endtask

  task automatic send_image(input logic [23:0] r0, input logic [23:0] r1,
                            input logic [23:0] r2, input int gap);
    send_row(r0, gap);
    send_row(r1, gap);
    send_row(r2, gap);
  endtask

  task automatic push_exp(input logic [31:0] w, input int idx);
    exp_q.push_back({(idx == NWIN - 1), 2'(idx), w});
  endtask

  // reference model: r0 is the first row sent (top, r=2); byte c of a row is column c
  task automatic push_model(input logic [23:0] r0, input logic [23:0] r1, input logic [23:0] r2);
    logic [7:0]  img [3][3];
    logic [23:0] rows [3];
    int top, hi;
    rows = '{r0, r1, r2};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        img[r][c] = rows[2-r][c*8 +: 8];
    for (int k = 0; k < NWIN; k++) begin
      top = 2 - k / 2;
      hi  = 2 - k % 2;
      push_exp({img[top][hi], img[top][hi-1], img[top-1][hi], img[top-1][hi-1]}, k);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard: every accepted window must match the expected queue; stalled windows must hold
  always @(negedge clk) begin
    if (rst && bus.pix_valid) begin
      if (hold_pend) begin
        check("hold_pixels", 64'(bus.pixels), 64'(hold_pix));
        check("hold_idx", 64'(bus.win_idx), 64'(hold_idx));
        check("hold_last", 64'(bus.win_last), 64'(hold_last));
      end
      if (bus.pix_ready) begin
        fire_cyc.push_back(cyc);
        check("window_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("win_pixels", 64'(bus.pixels), 64'(mon_e[31:0]));
          check("win_idx", 64'(bus.win_idx), 64'(mon_e[33:32]));
          check("win_last", 64'(bus.win_last), 64'(mon_e[34]));
        end
        hold_pend = 1'b0;
      end else begin
        hold_pend = 1'b1;
        hold_pix  = bus.pixels;
        hold_idx  = bus.win_idx;
        hold_last = bus.win_last;
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    bus.row_valid = 1'b0;
    bus.row_data  = '0;
    bus.pix_ready = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    // reset values
    check("reset_row_ready", 64'(bus.row_ready), 64'd1);
    check("reset_pix_valid", 64'(bus.pix_valid), 64'd0);
    check("reset_win_idx", 64'(bus.win_idx), 64'd0);
    check("reset_win_last", 64'(bus.win_last), 64'd0);
    check("reset_pixels", 64'(bus.pixels), 64'd0);
    check("reset_state", 64'(state_dbg), 64'd0);
    tick();
    tick();
    @(negedge clk) rst = 1'b1;
    tick();

    // X image, full throughput
    fire_cyc.delete();
    bus.pix_ready = 1'b1;
    push_exp(32'h01ffff01, 0);
    push_exp(32'hff0101ff, 1);
    push_exp(32'hff0101ff, 2);
    push_exp(32'h01ffff01, 3);
    send_image(24'h01ff01, 24'hff01ff, 24'h01ff01, 0);
    check("x_latency_valid", 64'(bus.pix_valid), 64'd1);
    check("x_first_idx", 64'(bus.win_idx), 64'd0);
    wait_drain();
    check("x_count", 64'(fire_cyc.size()), 64'd4);
    check("x_consecutive", 64'(fire_cyc[3] - fire_cyc[0]), 64'd3);
    tick();

    // backslash image
    push_exp(32'h01ffff01, 0);
    push_exp(32'hffff01ff, 1);
    push_exp(32'hff01ffff, 2);
    push_exp(32'h01ffff01, 3);
    send_image(24'h01ffff, 24'hff01ff, 24'hffff01, 0);
    wait_drain();
    tick();

    // backpressure: window 1 stalled for three cycles
    fire_cyc.delete();
    push_model(24'h01ff01, 24'hff01ff, 24'h01ff01);
    send_image(24'h01ff01, 24'hff01ff, 24'h01ff01, 0);
    tick();
    bus.pix_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_pixels", 64'(bus.pixels), 64'hff0101ff);
      check("bp_idx", 64'(bus.win_idx), 64'd1);
    end
    tick();
    bus.pix_ready = 1'b1;
    wait_drain();
    check("bp_count", 64'(fire_cyc.size()), 64'd4);
    tick();

    // row stalls of two cycles
    push_model(24'h01ff01, 24'hff01ff, 24'h01ff01);
    send_row(24'h01ff01, 2);
    check("stall_valid_r1", 64'(bus.pix_valid), 64'd0);
    send_row(24'hff01ff, 2);
    check("stall_valid_r2", 64'(bus.pix_valid), 64'd0);
    send_row(24'h01ff01, 2);
    check("stall_valid_r3", 64'(bus.pix_valid), 64'd1);
    wait_drain();
    tick();

    // asynchronous reset in the middle of a stream
    bus.pix_ready = 1'b0;
    send_image(24'h01ff01, 24'hff01ff, 24'h01ff01, 0);
    tick();
    tick();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_pix_valid", 64'(bus.pix_valid), 64'd0);
    check("midrst_row_ready", 64'(bus.row_ready), 64'd1);
    check("midrst_win_idx", 64'(bus.win_idx), 64'd0);
    check("midrst_pixels", 64'(bus.pixels), 64'd0);
    tick();
    @(negedge clk) rst = 1'b1;
    tick();
    bus.pix_ready = 1'b1;
    push_model(24'h01ff01, 24'hff01ff, 24'h01ff01);
    send_image(24'h01ff01, 24'hff01ff, 24'h01ff01, 0);
    check("postrst_idx", 64'(bus.win_idx), 64'd0);
    wait_drain();
    tick();

    // back-to-back images: X then backslash
    fire_cyc.delete();
    push_model(24'h01ff01, 24'hff01ff, 24'h01ff01);
    push_model(24'h01ffff, 24'hff01ff, 24'hffff01);
    send_image(24'h01ff01, 24'hff01ff, 24'h01ff01, 0);
`ifdef WIN_DBL_BUF_EN
    check("b2b_row_ready_streaming", 64'(bus.row_ready), 64'd1);
`else
    check("b2b_row_ready_streaming", 64'(bus.row_ready), 64'd0);
`endif
    send_image(24'h01ffff, 24'hff01ff, 24'hffff01, 0);
    wait_drain();
    check("b2b_count", 64'(fire_cyc.size()), 64'd8);
`ifdef WIN_DBL_BUF_EN
    check("b2b_no_bubble", 64'(fire_cyc[7] - fire_cyc[0]), 64'd7);
`else
    check("b2b_bubble", 64'((fire_cyc[4] - fire_cyc[3]) >= 2), 64'd1);
`endif
    tick();

    // random images, random row gaps, random consumer stalls
    rows_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 12; t++) begin
          ra = 24'($urandom);
          rb = 24'($urandom);
          rc = 24'($urandom);
          push_model(ra, rb, rc);
          send_image(ra, rb, rc, $urandom_range(0, 2));
        end
        rows_done = 1'b1;
      end
      begin
        rnd_n = 0;
        while (!(rows_done && exp_q.size() == 0) && rnd_n < 3000) begin
          tick();
          bus.pix_ready = ($urandom_range(0, 3) != 0);
          rnd_n++;
        end
      end
    join
    bus.pix_ready = 1'b1;
    wait_drain();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
